rtsnoc_to_wb_master: RTL and testbench
======================================

// Module: rtsnoc_to_wb_master
// PURPOSE
// - Bridge from an RTSNoC router local port to a Wishbone classic master port.
// - Receives request flits from the remote peer bridge (wishbone_slave_to_rtsnoc side).
// - Performs one WB read or write per request, then returns one response flit to that peer.
// - Sits at the router port of a WB peripheral cluster, so remote WB masters reach it over the NoC.
// PARAMETERS
// - WB_ADDR_WIDTH      6     WB address width; must be <= 27.
// - WB_NOC_DATA_WIDTH  32    WB data width and flit payload width; fixed at 32.
// - NOC_LOCAL_ADR      3'd1  own router local port.
// - NOC_X              0     own router X coordinate (SOC_SIZE_X bits).
// - NOC_Y              0     own router Y coordinate (SOC_SIZE_Y bits).
// - NOC_LOCAL_ADR_TGT  3'd0  peer bridge local port.
// - NOC_X_TGT          0     peer bridge X coordinate.
// - NOC_Y_TGT          0     peer bridge Y coordinate.
// - SOC_SIZE_X         1     log2 of mesh X size.
// - SOC_SIZE_Y         1     log2 of mesh Y size.
// - Derived: HDR = 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6; BUS = WB_NOC_DATA_WIDTH + HDR.
// PORTS
// - clk_i       in   1      single clock; all logic on the rising edge.
// - rst_i       in   1      reset, asynchronous, active-low.
// - wb_cyc_o    out  1      WB cycle.
// - wb_stb_o    out  1      WB strobe.
// - wb_adr_o    out  WB_ADDR_WIDTH  WB address.
// - wb_sel_o    out  4      WB byte selects.
// - wb_we_o     out  1      WB write enable.
// - wb_dat_o    out  32     WB write data.
// - wb_dat_i    in   32     WB read data.
// - wb_ack_i    in   1      WB acknowledge.
// - noc_din_o   out  BUS    flit to router.
// - noc_wr_o    out  1      one-cycle flit write strobe.
// - noc_rd_o    out  1      one-cycle flit consume strobe.
// - noc_dout_i  in   BUS    flit from router; valid when noc_nd_i is high.
// - noc_wait_i  in   1      router TX busy; no write while high.
// - noc_nd_i    in   1      new flit available; pulses for one cycle.
// BEHAVIOUR
// - Flit format, MSB to LSB: {X_orig, Y_orig, local_orig[2:0], X_dst, Y_dst, local_dst[2:0], data[31:0]}.
// - Command word (data field of request flit 0):
//   - [31] we; [30:27] sel; [WB_ADDR_WIDTH-1:0] adr; all other bits 0.
// - Request formats:
//   - Write request = command flit, then data flit.
//   - Read request = command flit only.
// - RX handshake:
//   - noc_dout_i is captured on the edge where noc_nd_i=1.
//   - noc_rd_o pulses for exactly one cycle on the following cycle.
//   - Every delivered flit is consumed.
//   - A flit is discarded unless dst=={NOC_X,NOC_Y,NOC_LOCAL_ADR} and orig=={NOC_X_TGT,NOC_Y_TGT,NOC_LOCAL_ADR_TGT}.
// - TX handshake:
//   - noc_wr_o is asserted for one cycle only when noc_wait_i=0.
//   - noc_din_o is held stable from that cycle until the next write.
//   - No further write is issued until noc_wait_i has returned low.
// - Response flit:
//   - orig = own coordinates; dst = peer coordinates.
//   - data = captured wb_dat_i for a read, 32'h0 for a write.
// - FSM states:
//   - IDLE: valid command flit -> latch adr/sel/we; go to GET_DATA if we=1, else WB.
//   - GET_DATA: valid flit -> latch wb_dat_o; go to WB. Invalid flits are consumed and the FSM stays.
//   - WB: cyc/stb high with adr/sel/we/dat stable until wb_ack_i. On ack: deassert cyc/stb/we on the next edge, capture wb_dat_i, go to RESP.
//   - RESP: wait for noc_wait_i=0, pulse noc_wr_o, go to IDLE.
// - wb_ack_i outside WB state is ignored; this covers a late or duplicate ack.
// - Flits arriving in WB/RESP are consumed and dropped, because the peer issues one outstanding request at a time.
// - No timeout; a missing ack keeps the FSM in WB.
// - Reset (rst_i=0, async): all outputs 0, including wb_sel_o=0 and noc_din_o=0; FSM returns to IDLE.
//   - Reset mid-transaction aborts it and sends no response.
// - Latency: wb_cyc_o rises 1 cycle after the last request flit is captured.
//   - noc_wr_o fires 1 cycle after ack, if noc_wait_i is low.
// STRUCTURE
// - Shared package rtsnoc_wb_pkg:
//   - HDR/BUS width functions.
//   - Command-word bit positions (WE_BIT=31, SEL_MSB=30, SEL_LSB=27).
//   - Header pack/unpack functions.
//   - Reused by wishbone_slave_to_rtsnoc.
// - One natural sub-module: rtsnoc_port_if.
//   - RX capture, address filter, rd pulse.
//   - TX hold register with wait-gated wr pulse.
// TESTING
// - Write: cmd {we=1, sel=F, adr=0} + data AABBCCDD -> one WB write, adr=0, dat_o=AABBCCDD, sel=F; response data=0 sent to peer.
// - Read: cmd {we=0, adr=3}, WB returns EEEEFFFF -> response flit data=EEEEFFFF, dst=peer, orig=own.
// - Misaddressed flit (wrong orig or dst) -> noc_rd_o pulses, no WB cycle, no response.
// - noc_wait_i held high 10 cycles in RESP -> noc_wr_o stays 0; it pulses once, 1 cycle after wait falls.
// - Duplicate ack_i cycle after completion -> no second WB cycle, no second response.
// - rst_i low during WB state -> all outputs 0 immediately; next request is handled normally.

Source files
------------

// File: rtl/rtsnoc_wb_pkg.sv
// Shared definitions for the RTSNoC <-> Wishbone bridge pair: flit header
// geometry, command-word layout, header pack/unpack helpers and bridge states.
package rtsnoc_wb_pkg;

  localparam int DATA_W  = 32;
  localparam int LOCAL_W = 3;

  // Command word layout carried in the data field of a request flit.
  localparam int WE_BIT  = 31;
  localparam int SEL_MSB = 30;
  localparam int SEL_LSB = 27;

  // Wide enough for any header used in practice (coordinates are a few bits).
  typedef logic [31:0] hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_DATA,
    ST_WB,
    ST_RESP
  } bridge_state_t;

  // Header width: two (X, Y, local) node identifiers.
  function automatic int hdr_width(input int sx, input int sy);
    return 2 * sx + 2 * sy + 2 * LOCAL_W;
  endfunction

  function automatic int bus_width(input int sx, input int sy);
    return DATA_W + hdr_width(sx, sy);
  endfunction

  function automatic hdr_t field_mask(input int n);
    return (hdr_t'(1) << n) - hdr_t'(1);
  endfunction

  // One node identifier {X, Y, local}, right-aligned.
  function automatic hdr_t node_id(input hdr_t x, input hdr_t y, input hdr_t l,
                                   input int sx, input int sy);
    return ((x & field_mask(sx)) << (sy + LOCAL_W)) |
           ((y & field_mask(sy)) << LOCAL_W) |
           (l & field_mask(LOCAL_W));
  endfunction

  // Full header {orig, dst}, right-aligned.
  function automatic hdr_t pack_hdr(input hdr_t orig, input hdr_t dst,
                                    input int sx, input int sy);
    return (orig << (sx + sy + LOCAL_W)) | (dst & field_mask(sx + sy + LOCAL_W));
  endfunction

  function automatic hdr_t hdr_orig(input hdr_t h, input int sx, input int sy);
    return h >> (sx + sy + LOCAL_W);
  endfunction

  function automatic hdr_t hdr_dst(input hdr_t h, input int sx, input int sy);
    return h & field_mask(sx + sy + LOCAL_W);
  endfunction

endpackage

// File: rtl/rtsnoc_to_wb_master_if.sv
// Bundle of the Wishbone master bus and the RTSNoC router local port seen by
// the bridge. "master" is the bridge side, "slave" is the environment side.
interface rtsnoc_to_wb_master_if #(
  parameter int ADDR_W = 6,
  parameter int BUS_W  = 42
);

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [3:0]        wb_sel_o;
  logic              wb_we_o;
  logic [31:0]       wb_dat_o;
  logic [31:0]       wb_dat_i;
  logic              wb_ack_i;

  logic [BUS_W-1:0]  noc_din_o;
  logic              noc_wr_o;
  logic              noc_rd_o;
  logic [BUS_W-1:0]  noc_dout_i;
  logic              noc_wait_i;
  logic              noc_nd_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i,
    output noc_din_o, noc_wr_o, noc_rd_o,
    input  noc_dout_i, noc_wait_i, noc_nd_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o,
    output wb_dat_i, wb_ack_i,
    input  noc_din_o, noc_wr_o, noc_rd_o,
    output noc_dout_i, noc_wait_i, noc_nd_i
  );

endinterface

// File: rtl/rtsnoc_port_if.sv
// Router local-port adapter: captures and filters incoming flits (always
// consuming them) and holds the outgoing flit with a wait-gated write pulse.
module rtsnoc_port_if
  import rtsnoc_wb_pkg::*;
#(
  parameter logic [2:0] NOC_LOCAL_ADR     = 3'd1,
  parameter int         NOC_X             = 0,
  parameter int         NOC_Y             = 0,
  parameter logic [2:0] NOC_LOCAL_ADR_TGT = 3'd0,
  parameter int         NOC_X_TGT         = 0,
  parameter int         NOC_Y_TGT         = 0,
  parameter int         SOC_SIZE_X        = 1,
  parameter int         SOC_SIZE_Y        = 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [bus_width(SOC_SIZE_X, SOC_SIZE_Y)-1:0] noc_dout_i,
  input  logic                                      noc_nd_i,
  input  logic                                      noc_wait_i,
  output logic [bus_width(SOC_SIZE_X, SOC_SIZE_Y)-1:0] noc_din_o,
  output logic                                      noc_wr_o,
  output logic                                      noc_rd_o,
  output logic                                      rx_valid_o,
  output logic [DATA_W-1:0]                         rx_data_o,
  input  logic                                      tx_req_i,
  input  logic [DATA_W-1:0]                         tx_data_i,
  output logic                                      tx_done_o
);

  localparam int   HDR    = hdr_width(SOC_SIZE_X, SOC_SIZE_Y);
  localparam int   BUS    = HDR + DATA_W;
  localparam hdr_t OWN_ID = node_id(hdr_t'(NOC_X), hdr_t'(NOC_Y),
                                    hdr_t'(NOC_LOCAL_ADR), SOC_SIZE_X, SOC_SIZE_Y);
  localparam hdr_t TGT_ID = node_id(hdr_t'(NOC_X_TGT), hdr_t'(NOC_Y_TGT),
                                    hdr_t'(NOC_LOCAL_ADR_TGT), SOC_SIZE_X, SOC_SIZE_Y);
  localparam hdr_t TX_HDR = pack_hdr(OWN_ID, TGT_ID, SOC_SIZE_X, SOC_SIZE_Y);

  logic [HDR-1:0] rx_hdr;
  logic           rx_match;

  assign rx_hdr   = noc_dout_i[BUS-1:DATA_W];
  assign rx_match = (hdr_dst(hdr_t'(rx_hdr), SOC_SIZE_X, SOC_SIZE_Y) == OWN_ID) &&
                    (hdr_orig(hdr_t'(rx_hdr), SOC_SIZE_X, SOC_SIZE_Y) == TGT_ID);

  // The write is issued on the edge where the requester is waiting and the
  // router is ready; the requester leaves its request state on that same edge.
  assign tx_done_o = tx_req_i && !noc_wait_i;

  // Capture every delivered flit, consume it next cycle, flag it if addressed to us.
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!rst_i) begin
      noc_rd_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      noc_rd_o   <= noc_nd_i;
      rx_valid_o <= noc_nd_i && rx_match;
      if (noc_nd_i) rx_data_o <= noc_dout_i[DATA_W-1:0];
    end
  end

  // Outgoing flit register: loaded with the write pulse, held until the next write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      noc_wr_o  <= 1'b0;
      noc_din_o <= '0;
    end else begin
      noc_wr_o <= tx_done_o;
      if (tx_done_o) noc_din_o <= {TX_HDR[HDR-1:0], tx_data_i};
    end
  end

endmodule

// File: rtl/rtsnoc_to_wb_master.sv
// RTSNoC -> Wishbone classic master bridge: turns a request flit sequence from
// the peer bridge into one WB read/write and answers with one response flit.
module rtsnoc_to_wb_master
  import rtsnoc_wb_pkg::*;
#(
  parameter int         WB_ADDR_WIDTH     = 6,
  parameter int         WB_NOC_DATA_WIDTH = 32,
  parameter logic [2:0] NOC_LOCAL_ADR     = 3'd1,
  parameter int         NOC_X             = 0,
  parameter int         NOC_Y             = 0,
  parameter logic [2:0] NOC_LOCAL_ADR_TGT = 3'd0,
  parameter int         NOC_X_TGT         = 0,
  parameter int         NOC_Y_TGT         = 0,
  parameter int         SOC_SIZE_X        = 1,
  parameter int         SOC_SIZE_Y        = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rtsnoc_to_wb_master_if.master  bus
);

  localparam int HDR = hdr_width(SOC_SIZE_X, SOC_SIZE_Y);
  localparam int BUS = WB_NOC_DATA_WIDTH + HDR;

  bridge_state_t     state;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_req;
  logic              tx_done;
  logic [DATA_W-1:0] resp_data;

  assign tx_req = (state == ST_RESP);

  rtsnoc_port_if #(
    .NOC_LOCAL_ADR     (NOC_LOCAL_ADR),
    .NOC_X             (NOC_X),
    .NOC_Y             (NOC_Y),
    .NOC_LOCAL_ADR_TGT (NOC_LOCAL_ADR_TGT),
    .NOC_X_TGT         (NOC_X_TGT),
    .NOC_Y_TGT         (NOC_Y_TGT),
    .SOC_SIZE_X        (SOC_SIZE_X),
    .SOC_SIZE_Y        (SOC_SIZE_Y)
  ) u_port (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .noc_dout_i (bus.noc_dout_i[BUS-1:0]),
    .noc_nd_i   (bus.noc_nd_i),
    .noc_wait_i (bus.noc_wait_i),
    .noc_din_o  (bus.noc_din_o),
    .noc_wr_o   (bus.noc_wr_o),
    .noc_rd_o   (bus.noc_rd_o),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .tx_req_i   (tx_req),
    .tx_data_i  (resp_data),
    .tx_done_o  (tx_done)
  );

  // Request/WB/response sequencer with registered Wishbone outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      bus.wb_cyc_o <= 1'b0;
      bus.wb_stb_o <= 1'b0;
      bus.wb_we_o  <= 1'b0;
      bus.wb_adr_o <= '0;
      bus.wb_sel_o <= '0;
      bus.wb_dat_o <= '0;
      resp_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            bus.wb_adr_o <= rx_data[WB_ADDR_WIDTH-1:0];
            bus.wb_sel_o <= rx_data[SEL_MSB:SEL_LSB];
            if (rx_data[WE_BIT]) begin
              state <= ST_GET_DATA;
            end else begin
              bus.wb_cyc_o <= 1'b1;
              bus.wb_stb_o <= 1'b1;
              bus.wb_we_o  <= 1'b0;
              state        <= ST_WB;
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_valid) begin
            bus.wb_dat_o <= rx_data;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            bus.wb_we_o  <= 1'b1;
            state        <= ST_WB;
          end
        end
        ST_WB: begin
          if (bus.wb_ack_i) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.wb_we_o  <= 1'b0;
            // A write answers with zero; a read returns the slave data.
            resp_data    <= bus.wb_we_o ? '0 : bus.wb_dat_i;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtsnoc_to_wb_master.sv
// Directed bench for rtsnoc_to_wb_master with hand-computed flits
// (SOC 1x1 bits: own node {0,0,1}, peer {0,0,0}, 10-bit header).
module tb_rtsnoc_to_wb_master;

  localparam int        AW      = 6;
  localparam int        BUS     = 42;
  localparam logic [9:0] REQ_HDR = 10'h001;  // orig=peer, dst=own
  localparam logic [9:0] RSP_HDR = 10'h020;  // orig=own,  dst=peer
  localparam logic [9:0] BAD_ORG = 10'h041;  // orig local=2, dst=own
  localparam logic [9:0] BAD_DST = 10'h003;  // orig=peer, dst local=3

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   seen;

  rtsnoc_to_wb_master_if #(.ADDR_W(AW), .BUS_W(BUS)) bus ();

  rtsnoc_to_wb_master #(
    .WB_ADDR_WIDTH (AW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_flit(input logic [BUS-1:0] flit);
    bus.noc_dout_i = flit;
    bus.noc_nd_i   = 1'b1;
    step();
    bus.noc_nd_i   = 1'b0;
    bus.noc_dout_i = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, 64'(bus.wb_cyc_o), 64'd0);
    check({tag, "_stb"}, 64'(bus.wb_stb_o), 64'd0);
    check({tag, "_we"},  64'(bus.wb_we_o),  64'd0);
    check({tag, "_adr"}, 64'(bus.wb_adr_o), 64'd0);
    check({tag, "_sel"}, 64'(bus.wb_sel_o), 64'd0);
    check({tag, "_dat"}, 64'(bus.wb_dat_o), 64'd0);
    check({tag, "_din"}, 64'(bus.noc_din_o), 64'd0);
    check({tag, "_wr"},  64'(bus.noc_wr_o), 64'd0);
    check({tag, "_rd"},  64'(bus.noc_rd_o), 64'd0);
  endtask

  // Count cycles over a window in which a WB cycle or flit write shows up.
  task automatic quiet_window(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.wb_cyc_o || bus.noc_wr_o) hits++;
    end
  endtask

  initial begin
    bus.wb_dat_i   = '0;
    bus.wb_ack_i   = 1'b0;
    bus.noc_dout_i = '0;
    bus.noc_wait_i = 1'b0;
    bus.noc_nd_i   = 1'b0;

    // Reset state
    step();
    step();
    check_all_zero("reset");
    rst_i = 1'b1;
    step();

    // Write: cmd {we=1, sel=F, adr=0}, data AABBCCDD
    send_flit({REQ_HDR, 32'hF800_0000});
    check("wr_cmd_rd", 64'(bus.noc_rd_o), 64'd1);
    step();
    check("wr_rd_one_cycle", 64'(bus.noc_rd_o), 64'd0);
    send_flit({REQ_HDR, 32'hAABB_CCDD});
    check("wr_cyc_not_yet", 64'(bus.wb_cyc_o), 64'd0);
    step();
    check("wr_cyc", 64'(bus.wb_cyc_o), 64'd1);
    check("wr_stb", 64'(bus.wb_stb_o), 64'd1);
    check("wr_we",  64'(bus.wb_we_o),  64'd1);
    check("wr_adr", 64'(bus.wb_adr_o), 64'd0);
    check("wr_sel", 64'(bus.wb_sel_o), 64'hF);
    check("wr_dat", 64'(bus.wb_dat_o), 64'hAABB_CCDD);
    step();
    step();
    check("wr_hold_cyc", 64'(bus.wb_cyc_o), 64'd1);
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    check("wr_ack_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("wr_ack_we",  64'(bus.wb_we_o),  64'd0);
    check("wr_ack_nowr", 64'(bus.noc_wr_o), 64'd0);
    step();
    check("wr_resp_wr",  64'(bus.noc_wr_o),  64'd1);
    check("wr_resp_din", 64'(bus.noc_din_o), 64'({RSP_HDR, 32'h0}));
    step();
    check("wr_resp_pulse", 64'(bus.noc_wr_o),  64'd0);
    check("wr_resp_hold",  64'(bus.noc_din_o), 64'({RSP_HDR, 32'h0}));

    // Read: cmd {we=0, adr=3}, slave returns EEEEFFFF
    send_flit({REQ_HDR, 32'h0000_0003});
    step();
    check("rd_cyc", 64'(bus.wb_cyc_o), 64'd1);
    check("rd_we",  64'(bus.wb_we_o),  64'd0);
    check("rd_adr", 64'(bus.wb_adr_o), 64'd3);
    check("rd_sel", 64'(bus.wb_sel_o), 64'd0);
    bus.wb_dat_i = 32'hEEEE_FFFF;
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    check("rd_ack_cyc", 64'(bus.wb_cyc_o), 64'd0);
    step();
    check("rd_resp_wr",  64'(bus.noc_wr_o),  64'd1);
    check("rd_resp_din", 64'(bus.noc_din_o), 64'({RSP_HDR, 32'hEEEE_FFFF}));

    // Misaddressed flits: consumed, no WB cycle, no response
    send_flit({BAD_ORG, 32'h0000_0003});
    check("bad_org_rd", 64'(bus.noc_rd_o), 64'd1);
    quiet_window(6, seen);
    check("bad_org_quiet", 64'(seen), 64'd0);
    send_flit({BAD_DST, 32'h0000_0003});
    check("bad_dst_rd", 64'(bus.noc_rd_o), 64'd1);
    quiet_window(6, seen);
    check("bad_dst_quiet", 64'(seen), 64'd0);

    // Router busy for 10 cycles while a read response is pending
    bus.noc_wait_i = 1'b1;
    send_flit({REQ_HDR, 32'h0000_0005});
    step();
    check("wait_rd_adr", 64'(bus.wb_adr_o), 64'd5);
    bus.wb_dat_i = 32'h0102_0304;
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.noc_wr_o) seen++;
    end
    check("wait_no_wr", 64'(seen), 64'd0);
    bus.noc_wait_i = 1'b0;
    step();
    check("wait_wr",  64'(bus.noc_wr_o),  64'd1);
    check("wait_din", 64'(bus.noc_din_o), 64'({RSP_HDR, 32'h0102_0304}));
    step();
    check("wait_wr_once", 64'(bus.noc_wr_o), 64'd0);

    // Write with a stray flit in GET_DATA, then a duplicate ack
    send_flit({REQ_HDR, 32'hF800_0004});
    step();
    send_flit({BAD_ORG, 32'hDEAD_BEEF});
    step();
    check("gd_stray_cyc", 64'(bus.wb_cyc_o), 64'd0);
    send_flit({REQ_HDR, 32'h1122_3344});
    step();
    check("gd_cyc", 64'(bus.wb_cyc_o), 64'd1);
    check("gd_adr", 64'(bus.wb_adr_o), 64'd4);
    check("gd_dat", 64'(bus.wb_dat_o), 64'h1122_3344);
    bus.wb_ack_i = 1'b1;
    step();
    step();
    bus.wb_ack_i = 1'b0;
    check("dup_wr",  64'(bus.noc_wr_o),  64'd1);
    check("dup_din", 64'(bus.noc_din_o), 64'({RSP_HDR, 32'h0}));
    quiet_window(6, seen);
    check("dup_quiet", 64'(seen), 64'd0);

    // Reset in WB state aborts the transaction
    send_flit({REQ_HDR, 32'h0000_0002});
    step();
    check("rst_pre_cyc", 64'(bus.wb_cyc_o), 64'd1);
    rst_i = 1'b0;
    #1;
    check_all_zero("midrst");
    #3;
    rst_i = 1'b1;
    quiet_window(5, seen);
    check("rst_no_resp", 64'(seen), 64'd0);

    // Normal read after the aborted one
    send_flit({REQ_HDR, 32'h0000_0001});
    step();
    check("post_rst_cyc", 64'(bus.wb_cyc_o), 64'd1);
    check("post_rst_adr", 64'(bus.wb_adr_o), 64'd1);
    bus.wb_dat_i = 32'h1234_5678;
    bus.wb_ack_i = 1'b1;
    step();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    step();
    check("post_rst_wr",  64'(bus.noc_wr_o),  64'd1);
    check("post_rst_din", 64'(bus.noc_din_o), 64'({RSP_HDR, 32'h1234_5678}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
